// File: rtl/uart_tx_sched.sv
// Two-requester round-robin UART transmitter: 8N1 frames (8E1 when UART_TX_PARITY_EN is defined).
// Owns the bit-period counter and the frame FSM; ready is combinational, tx/busy are registered.
module uart_tx_sched #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             last_grant;
`ifdef UART_TX_PARITY_EN
  logic             par;
`endif

  logic       idle, pick0, pick1, accept, bit_end;
  logic [7:0] acc_data;

  // With both requesters valid, the one not served last wins.
  assign idle       = (state == IDLE);
  assign pick0      = req0_valid & (~req1_valid | last_grant);
  assign pick1      = req1_valid & (~req0_valid | ~last_grant);
  assign req0_ready = idle & ~rst & pick0;
  assign req1_ready = idle & ~rst & pick1;
  assign accept     = req0_ready | req1_ready;
  assign acc_data   = req1_ready ? req1_data : req0_data;
  assign bit_end    = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      if (!idle) cnt <= bit_end ? '0 : cnt + CNT_W'(1);
      case (state)
        IDLE: if (accept) begin
          state      <= START;
          cnt        <= '0;
          bit_idx    <= '0;
          shreg      <= acc_data;
          grant_id   <= req1_ready;
          last_grant <= req1_ready;
          tx         <= 1'b0;
          busy       <= 1'b1;
`ifdef UART_TX_PARITY_EN
          par        <= ^acc_data;
`endif
        end
        START: if (bit_end) begin
          state <= DATA;
          tx    <= shreg[0];
          shreg <= shreg >> 1;
        end
        DATA: if (bit_end) begin
          if (bit_idx == 3'd7) begin
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            state   <= PARITY;
            tx      <= par;
`else
            state   <= STOP;
            tx      <= 1'b1;
`endif
          end else begin
            bit_idx <= bit_idx + 3'd1;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          state <= STOP;
          tx    <= 1'b1;
        end
`endif
        STOP: if (bit_end) begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
